// File: rtl/sound_dma_arbiter_pkg.sv
// ============================================================================
//  sound_dma_arbiter_pkg
//  Shared definitions for the sound DMA arbiter: FSM encoding, bus width,
//  default timeout and the round-robin pointer advance helper.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package sound_dma_arbiter_pkg;

    localparam int DMA_W           = 16;
    localparam int TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } dma_state_t;

    // Pointer moves one past the granted channel, highest index wraps to 0.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sound_dma_arbiter_if.sv
// ============================================================================
//  sound_dma_arbiter_if
//  DMA memory port shared by the sound channels; master = arbiter side.
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface sound_dma_arbiter_if;

    logic [sound_dma_arbiter_pkg::DMA_W-1:0] addrDMA;
    logic                                    startDMA;
    logic                                    wDMA;
    logic [sound_dma_arbiter_pkg::DMA_W-1:0] toSaveDMA;
    logic [sound_dma_arbiter_pkg::DMA_W-1:0] inDMA;
    logic                                    rdyDMA;

    modport master (
        output addrDMA, startDMA, wDMA, toSaveDMA,
        input  inDMA, rdyDMA
    );

    modport slave (
        input  addrDMA, startDMA, wDMA, toSaveDMA,
        output inDMA, rdyDMA
    );

endinterface

`default_nettype wire

// File: rtl/sound_dma_arbiter_rr_pick.sv
// ============================================================================
//  sound_rr_pick
//  Combinational round-robin picker: first pending channel at or after rr_ptr.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module sound_rr_pick #(
    parameter int N_CH  = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_CH-1:0]  pending,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [IDX_W-1:0] winner,
    output logic             valid
);

    logic [IDX_W-1:0] idx;

    // Scan from the farthest candidate back to rr_ptr so the nearest one wins.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            idx = IDX_W'((int'(rr_ptr) + k) % N_CH);
            if (pending[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sound_dma_arbiter.sv
// ============================================================================
//  sound_dma_arbiter
//  Round-robin arbiter serialising per-channel read/write requests onto a
//  single DMA memory port, with completion/timeout/drop pulses.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module sound_dma_arbiter
    import sound_dma_arbiter_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_CH-1:0]         req_start,
    input  logic [N_CH-1:0]         req_write,
    input  logic [DMA_W*N_CH-1:0]   req_addr,
    input  logic [DMA_W*N_CH-1:0]   req_wdata,
    output logic [N_CH-1:0]         req_busy,
    output logic [N_CH-1:0]         done,
    output logic [N_CH-1:0]         err,
    output logic [N_CH-1:0]         drop,
    output logic [DMA_W-1:0]        rd_data,
    sound_dma_arbiter_if.master     dma
);

    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    dma_state_t        state;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  act;
    logic [7:0]        timer;

    logic [N_CH-1:0]   pending;
    logic [DMA_W-1:0]  cap_addr  [N_CH];
    logic [DMA_W-1:0]  cap_wdata [N_CH];
    logic [N_CH-1:0]   cap_write;

    logic [IDX_W-1:0]  winner;
    logic              pick_valid;
    logic              grant;

    sound_rr_pick #(
        .N_CH  (N_CH),
        .IDX_W (IDX_W)
    ) u_pick (
        .pending (pending),
        .rr_ptr  (rr_ptr),
        .winner  (winner),
        .valid   (pick_valid)
    );

    assign grant = (state == ST_IDLE) && pick_valid;

    always_comb begin
        req_busy = pending;
        if (state != ST_IDLE) begin
            req_busy[act] = 1'b1;
        end
    end

    // Request capture runs independently of the FSM; a busy channel's start is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= '0;
            cap_write <= '0;
            drop      <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cap_addr[i]  <= '0;
                cap_wdata[i] <= '0;
            end
        end else begin
            drop <= req_start & req_busy;
            for (int i = 0; i < N_CH; i++) begin
                if (req_start[i] && !req_busy[i]) begin
                    pending[i]   <= 1'b1;
                    cap_write[i] <= req_write[i];
                    cap_addr[i]  <= req_addr[DMA_W*i +: DMA_W];
                    cap_wdata[i] <= req_wdata[DMA_W*i +: DMA_W];
                end else if (grant && (winner == IDX_W'(i))) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            rr_ptr        <= '0;
            act           <= '0;
            timer         <= '0;
            done          <= '0;
            err           <= '0;
            rd_data       <= '0;
            dma.addrDMA   <= '0;
            dma.startDMA  <= 1'b0;
            dma.wDMA      <= 1'b0;
            dma.toSaveDMA <= '0;
        end else begin
            done         <= '0;
            err          <= '0;
            dma.startDMA <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        dma.addrDMA   <= cap_addr[winner];
                        dma.toSaveDMA <= cap_wdata[winner];
                        dma.wDMA      <= cap_write[winner];
                        dma.startDMA  <= 1'b1;
                        act           <= winner;
                        rr_ptr        <= IDX_W'(rr_next(int'(winner), N_CH));
                        state         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    timer <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // An acknowledge in the final timer cycle still counts as success.
                    if (dma.rdyDMA) begin
                        if (!dma.wDMA) begin
                            rd_data <= dma.inDMA;
                        end
                        done[act] <= 1'b1;
                        state     <= ST_IDLE;
                    end else if (timer == 8'(TIMEOUT)) begin
                        if (!dma.wDMA) begin
                            rd_data <= '0;
                        end
                        done[act] <= 1'b1;
                        err[act]  <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sound_dma_arbiter.sv
// ============================================================================
//  tb_sound_dma_arbiter
//  Self-checking bench: directed scenarios plus randomized batches against a
//  transaction-level round-robin model.
//  Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_sound_dma_arbiter;
    import sound_dma_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_start, req_write;
    logic [16*N-1:0] req_addr, req_wdata;
    logic [N-1:0]    busy, done, err, drop;
    logic [15:0]     rd_data;

    sound_dma_arbiter_if dma();

    sound_dma_arbiter #(.N_CH(N), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_start (req_start),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_busy  (busy),
        .done      (done),
        .err       (err),
        .drop      (drop),
        .rd_data   (rd_data),
        .dma       (dma)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Transaction-level model: queued requests per channel, rotating priority.
    logic        m_pend  [N];
    logic [15:0] m_addr  [N];
    logic [15:0] m_wdata [N];
    logic        m_write [N];
    int          m_ptr;
    logic [15:0] m_rd;

    function automatic void m_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 1'b0; m_addr[i] = '0; m_wdata[i] = '0; m_write[i] = 1'b0;
        end
        m_ptr = 0;
        m_rd  = '0;
    endfunction

    function automatic int m_grant();
        for (int k = 0; k < N; k++) begin
            int c = (m_ptr + k) % N;
            if (m_pend[c]) begin
                m_pend[c] = 1'b0;
                m_ptr = (c + 1) % N;
                return c;
            end
        end
        return -1;
    endfunction

    function automatic void m_complete(input int ch, input bit acked, input logic [15:0] data);
        if (!m_write[ch]) m_rd = acked ? data : 16'h0;
    endfunction

    task automatic post(input logic [N-1:0] mask, input logic [N-1:0] wr,
                        input logic [16*N-1:0] a, input logic [16*N-1:0] d);
        req_start = mask; req_write = wr; req_addr = a; req_wdata = d;
        for (int i = 0; i < N; i++) begin
            if (mask[i] && !m_pend[i]) begin
                m_pend[i] = 1'b1; m_write[i] = wr[i];
                m_addr[i] = a[16*i +: 16]; m_wdata[i] = d[16*i +: 16];
            end
        end
        @(negedge clk);
        req_start = '0;
    endtask

    // Memory side: wait for a strobe, answer after 'delay' cycles (or never), return what was seen.
    task automatic serve(input int delay, input bit ack, input logic [15:0] data,
                         output bit seen, output logic [15:0] a, output logic w,
                         output logic [15:0] wd, output logic [N-1:0] d,
                         output logic [N-1:0] e, output logic [15:0] rd, output int lat);
        int n = 0;
        seen = 1'b0; a = '0; w = 1'b0; wd = '0; d = '0; e = '0; rd = '0; lat = 0;
        while (dma.startDMA !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        if (dma.startDMA !== 1'b1) return;
        seen = 1'b1; a = dma.addrDMA; w = dma.wDMA; wd = dma.toSaveDMA;
        if (ack) begin
            repeat (delay) @(negedge clk);
            lat = delay;
            dma.inDMA = data; dma.rdyDMA = 1'b1;
            @(negedge clk);
            dma.rdyDMA = 1'b0;
            lat++;
        end
        while (done === '0 && lat < TO + 20) begin @(negedge clk); lat++; end
        d = done; e = err; rd = rd_data;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({busy, done, err, drop, rd_data} !== '0)
            $display("FAIL reset_req_side: got busy=%b done=%b err=%b drop=%b rd=%h, need all 0", busy, done, err, drop, rd_data);
        else passed++;
        total++;
        if ({dma.addrDMA, dma.startDMA, dma.wDMA, dma.toSaveDMA} !== '0)
            $display("FAIL reset_dma_side: got addr=%h start=%b w=%b wd=%h, need all 0", dma.addrDMA, dma.startDMA, dma.wDMA, dma.toSaveDMA);
        else passed++;
        rst_n = 1'b1;
        m_reset();
        @(negedge clk);
    endtask

    task automatic test_single_read();
        bit seen; logic [15:0] a, wd, rd; logic w; logic [N-1:0] d, e; int lat, ch;
        post(4'b0010, 4'b0000, {16'h0, 16'h0, 16'h0123, 16'h0}, '0);
        total++;
        if (dma.startDMA !== 1'b0 || busy[1] !== 1'b1)
            $display("FAIL read_latency1: start=%b busy1=%b, need start=0 busy1=1", dma.startDMA, busy[1]);
        else passed++;
        @(negedge clk);
        total++;
        if (dma.startDMA !== 1'b1 || dma.addrDMA !== 16'h0123 || dma.wDMA !== 1'b0)
            $display("FAIL read_issue: start=%b addr=%h w=%b, need 1/0123/0", dma.startDMA, dma.addrDMA, dma.wDMA);
        else passed++;
        ch = m_grant();
        serve(3, 1'b1, 16'hBEEF, seen, a, w, wd, d, e, rd, lat);
        m_complete(ch, 1'b1, 16'hBEEF);
        total++;
        if (!seen || lat != 4 || d !== 4'b0010 || e !== 4'b0000)
            $display("FAIL read_done: seen=%0d lat=%0d done=%b err=%b, need 1/4/0010/0000", seen, lat, d, e);
        else passed++;
        total++;
        if (rd !== m_rd) $display("FAIL read_data: got %h need %h", rd, m_rd); else passed++;
        @(negedge clk);
        total++;
        if (done !== '0) $display("FAIL done_single_pulse: got %b need 0000", done); else passed++;
    endtask

    task automatic test_write();
        bit seen; logic [15:0] a, wd, rd; logic w; logic [N-1:0] d, e; int lat, ch;
        post(4'b0100, 4'b0100, {16'h0, 16'h0040, 32'h0}, {16'h0, 16'h5A5A, 32'h0});
        ch = m_grant();
        serve(2, 1'b1, 16'h1111, seen, a, w, wd, d, e, rd, lat);
        m_complete(ch, 1'b1, 16'h1111);
        total++;
        if (!seen || a !== m_addr[ch] || w !== 1'b1 || wd !== m_wdata[ch])
            $display("FAIL write_issue: addr=%h w=%b wd=%h, need %h/1/%h", a, w, wd, m_addr[ch], m_wdata[ch]);
        else passed++;
        total++;
        if (lat != 3 || d !== 4'b0100 || e !== '0 || rd !== m_rd)
            $display("FAIL write_done: lat=%0d done=%b err=%b rd=%h, need 3/0100/0000/%h", lat, d, e, rd, m_rd);
        else passed++;
    endtask

    task automatic test_simultaneous();
        bit seen; logic [15:0] a, wd, rd, data; logic w; logic [N-1:0] d, e; int lat, ch;
        int order [2] = '{0, 3};
        rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; m_reset();
        post(4'hF, 4'h0, {16'h1003, 16'h1002, 16'h1001, 16'h1000}, '0);
        for (int k = 0; k < N; k++) begin
            ch = m_grant();
            data = 16'($urandom) | 16'h8000;
            serve($urandom_range(1, 5), 1'b1, data, seen, a, w, wd, d, e, rd, lat);
            m_complete(ch, 1'b1, data);
            total++;
            if (a !== 16'h1000 + 16'(k) || d !== (4'b0001 << k) || rd !== data)
                $display("FAIL all_order_%0d: addr=%h done=%b rd=%h, need %h/%b/%h", k, a, d, rd, 16'h1000 + 16'(k), 4'b0001 << k, data);
            else passed++;
        end
        post(4'b1001, 4'h0, {16'h2003, 32'h0, 16'h2000}, '0);
        for (int k = 0; k < 2; k++) begin
            ch = m_grant();
            data = 16'($urandom) | 16'h8000;
            serve(1, 1'b1, data, seen, a, w, wd, d, e, rd, lat);
            m_complete(ch, 1'b1, data);
            total++;
            if (a !== (order[k] == 0 ? 16'h2000 : 16'h2003) || d !== (4'b0001 << order[k]))
                $display("FAIL pair_order_%0d: addr=%h done=%b, need channel %0d", k, a, d, order[k]);
            else passed++;
        end
    endtask

    task automatic test_timeout();
        bit seen; logic [15:0] a, wd, rd; logic w; logic [N-1:0] d, e; int lat, ch;
        post(4'b1100, 4'h0, {16'h3003, 16'h3002, 32'h0}, '0);
        ch = m_grant();
        serve(0, 1'b0, 16'h0, seen, a, w, wd, d, e, rd, lat);
        m_complete(ch, 1'b0, 16'h0);
        total++;
        if (!seen || a !== m_addr[ch] || d !== (4'b0001 << ch) || e !== (4'b0001 << ch) || lat != TO + 2)
            $display("FAIL timeout_abort: addr=%h done=%b err=%b lat=%0d, need ch%0d lat %0d", a, d, e, lat, ch, TO + 2);
        else passed++;
        total++;
        if (rd !== 16'h0) $display("FAIL timeout_rd: got %h need 0000", rd); else passed++;
        ch = m_grant();
        serve(2, 1'b1, 16'h4242, seen, a, w, wd, d, e, rd, lat);
        m_complete(ch, 1'b1, 16'h4242);
        total++;
        if (!seen || a !== m_addr[ch] || d !== (4'b0001 << ch) || e !== '0 || rd !== m_rd)
            $display("FAIL timeout_next: addr=%h done=%b err=%b rd=%h, need ch%0d rd %h", a, d, e, rd, ch, m_rd);
        else passed++;
    endtask

    task automatic test_drop();
        int ch;
        post(4'b0001, 4'h0, {48'h0, 16'h0A00}, '0);
        total++;
        if (busy[0] !== 1'b1) $display("FAIL drop_busy: got %b need 1", busy[0]); else passed++;
        post(4'b0001, 4'h0, {48'h0, 16'h0B00}, '0);
        ch = m_grant();
        total++;
        if (drop !== 4'b0001 || dma.startDMA !== 1'b1 || dma.addrDMA !== m_addr[ch])
            $display("FAIL drop_pulse: drop=%b start=%b addr=%h, need 0001/1/%h", drop, dma.startDMA, dma.addrDMA, m_addr[ch]);
        else passed++;
        @(negedge clk);
        total++;
        if (drop !== '0) $display("FAIL drop_single: got %b need 0000", drop); else passed++;
        dma.inDMA = 16'h7777; dma.rdyDMA = 1'b1;
        @(negedge clk);
        dma.rdyDMA = 1'b0;
        m_complete(ch, 1'b1, 16'h7777);
        total++;
        if (done !== 4'b0001 || rd_data !== m_rd)
            $display("FAIL drop_done: done=%b rd=%h, need 0001/%h", done, rd_data, m_rd);
        else passed++;
    endtask

    task automatic test_reset_mid();
        bit seen; logic [15:0] a, wd, rd; logic w; logic [N-1:0] d, e; int lat, ch;
        post(4'b0010, 4'h0, {32'h0, 16'h0C00, 16'h0}, '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, err, drop, rd_data, dma.addrDMA, dma.startDMA, dma.wDMA, dma.toSaveDMA} !== '0)
            $display("FAIL mid_reset_outputs: busy=%b rd=%h addr=%h, need all 0", busy, rd_data, dma.addrDMA);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        dma.inDMA = 16'hFFFF; dma.rdyDMA = 1'b1;
        @(negedge clk);
        dma.rdyDMA = 1'b0;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (done !== '0 || busy !== '0 || rd_data !== '0)
                $display("FAIL mid_reset_late_rdy_%0d: done=%b busy=%b rd=%h, need 0", k, done, busy, rd_data);
            else passed++;
            @(negedge clk);
        end
        post(4'b0100, 4'h0, {16'h0, 16'h0D00, 32'h0}, '0);
        ch = m_grant();
        serve(1, 1'b1, 16'h1234, seen, a, w, wd, d, e, rd, lat);
        m_complete(ch, 1'b1, 16'h1234);
        total++;
        if (!seen || a !== m_addr[ch] || d !== (4'b0001 << ch) || rd !== m_rd)
            $display("FAIL mid_reset_recover: addr=%h done=%b rd=%h, need %h ch%0d %h", a, d, rd, m_addr[ch], ch, m_rd);
        else passed++;
    endtask

    task automatic test_random();
        bit seen, ack; logic [15:0] a, wd, rd, data; logic w; logic [N-1:0] d, e; int lat, ch, dly;
        logic [N-1:0] mask, wr; logic [16*N-1:0] ad, wdv;
        for (int r = 0; r < 25; r++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            wr = N'($urandom);
            for (int i = 0; i < N; i++) begin
                ad[16*i +: 16] = 16'($urandom);
                wdv[16*i +: 16] = 16'($urandom);
            end
            post(mask, wr, ad, wdv);
            ch = m_grant();
            while (ch >= 0) begin
                ack  = ($urandom_range(0, 7) != 0);
                dly  = $urandom_range(1, 6);
                data = 16'($urandom);
                serve(dly, ack, data, seen, a, w, wd, d, e, rd, lat);
                m_complete(ch, ack, data);
                total++;
                if (!seen || a !== m_addr[ch] || w !== m_write[ch] || (w && wd !== m_wdata[ch]))
                    $display("FAIL rand_issue_r%0d: addr=%h w=%b wd=%h, need ch%0d %h/%b/%h", r, a, w, wd, ch, m_addr[ch], m_write[ch], m_wdata[ch]);
                else passed++;
                total++;
                if (d !== (4'b0001 << ch) || e !== (ack ? 4'b0000 : (4'b0001 << ch)) ||
                    lat != (ack ? dly + 1 : TO + 2) || rd !== m_rd)
                    $display("FAIL rand_done_r%0d: done=%b err=%b lat=%0d rd=%h, need ch%0d ack=%0d rd %h", r, d, e, lat, rd, ch, ack, m_rd);
                else passed++;
                ch = m_grant();
            end
            total++;
            if (busy !== '0) $display("FAIL rand_idle_r%0d: busy=%b need 0000", r, busy); else passed++;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; req_start = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        dma.inDMA = '0; dma.rdyDMA = 1'b0;
        m_reset();
        test_reset();
        test_single_read();
        test_write();
        test_simultaneous();
        test_timeout();
        test_drop();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
